// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one partial product per clock, signed/unsigned.
// Optional macro EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic [2*DATA_W-1:0]   product,
    output logic                  busy,
    output logic                  done,
    output logic                  ready
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [2*DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]     r_b;
    logic [2*DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg;
    logic [2*DATA_W-1:0]   r_prod;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ready;

    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;
    logic [2*DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]     w_b_nxt;
    logic                  w_last;

    // Magnitudes are unsigned, so -2^(DATA_W-1) maps to 2^(DATA_W-1) cleanly
    assign w_mag_a   = (signed_mode && op_a[DATA_W-1]) ? -op_a : op_a;
    assign w_mag_b   = (signed_mode && op_b[DATA_W-1]) ? -op_b : op_b;
    assign w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_b_nxt   = r_b >> 1;

`ifdef EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_W'(DATA_W - 1)) || (w_b_nxt == '0);
`else
    assign w_last = (r_cnt == CNT_W'(DATA_W - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_prod  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= {{DATA_W{1'b0}}, w_mag_a};
                        r_b     <= w_mag_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= signed_mode & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_a   <= r_a << 1;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_prod  <= r_neg ? -w_acc_nxt : w_acc_nxt;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign product = r_prod;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ready   = r_ready;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: 16-bit directed cases
// plus an exhaustive 4-bit sweep in both signed and unsigned modes.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] product16;
    logic        busy16, done16, ready16;

    logic        start4, sm4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;
    logic        busy4, done4, ready4;

    int n_chk;
    int n_err;

    logic [31:0] q16[$];
    logic [7:0]  q4[$];
    logic [31:0] last16;

    shift_add_multiplier #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .op_a(a16), .op_b(b16), .product(product16),
        .busy(busy16), .done(done16), .ready(ready16)
    );

    shift_add_multiplier #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .op_a(a4), .op_b(b4), .product(product4),
        .busy(busy4), .done(done4), .ready(ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        if (s) return 32'(sa * sb);
        return {16'b0, a} * {16'b0, b};
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic signed [7:0] sa, sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        if (s) return 8'(sa * sb);
        return {4'b0, a} * {4'b0, b};
    endfunction

    // Cycles from the start cycle to the done cycle
    function automatic int explat(input logic [63:0] mag, input int w);
`ifdef EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < w; i++)
            if (mag[i]) h = i + 1;
        return ((h == 0) ? 1 : h) + 1;
`else
        return (mag == 64'd0) ? w + 1 : w + 1;
`endif
    endfunction

    function automatic logic [15:0] mag16(input logic [15:0] b, input logic s);
        return (s && b[15]) ? 16'(-b) : b;
    endfunction

    function automatic logic [3:0] mag4(input logic [3:0] b, input logic s);
        return (s && b[3]) ? 4'(-b) : b;
    endfunction

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) chk("unexp_done16", 1, 0);
            else chk("prod16", product16, q16.pop_front());
        end
        if (done4) begin
            chk("done4_busy", busy4, 1);
            chk("done4_ready", ready4, 0);
            if (q4.size() == 0) chk("unexp_done4", 1, 0);
            else chk("prod4", product4, q4.pop_front());
        end
    end

    task automatic wait_ready16();
        @(negedge clk);
        for (int i = 0; i < 60 && !ready16; i++) @(negedge clk);
        chk("ready16_timeout", ready16, 1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int lat, busyc, el;
        logic rdy_bad;
        logic [31:0] e;
        wait_ready16();
        e  = ref16(a, b, s);
        el = explat(64'(mag16(b, s)), 16);
        a16 = a; b16 = b; sm16 = s; start16 = 1'b1;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'h5A5A; b16 = 16'hA5A5; sm16 = ~s;
        lat = 0; busyc = 0; rdy_bad = 1'b0;
        while (lat < 100) begin
            lat++;
            if (busy16) busyc++;
            if (ready16) rdy_bad = 1'b1;
            if (lat == 1) chk("hold16", product16, last16);
            if (done16) break;
            @(negedge clk);
        end
        chk("lat16", lat, el);
        chk("busy16_cycles", busyc, el);
        chk("ready16_low", rdy_bad, 0);
        last16 = e;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int lat;
        @(negedge clk);
        for (int i = 0; i < 30 && !ready4; i++) @(negedge clk);
        a4 = a; b4 = b; sm4 = s; start4 = 1'b1;
        q4.push_back(ref4(a, b, s));
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("lat4", lat, explat(64'(mag4(b, s)), 4));
    endtask

    initial begin
        int lat, el, pulse;
        n_chk = 0; n_err = 0; last16 = '0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_prod", product16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_ready", ready16, 1);
        chk("rst_ready4", ready4, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        op16(16'hFFFF, 16'hFFFF, 1'b0);
        op16(16'hFFFD, 16'h0005, 1'b1);
        op16(16'h8000, 16'h8000, 1'b1);
        op16(16'h8000, 16'h0001, 1'b1);
        op16(16'h1234, 16'h0000, 1'b0);
        op16(16'h1234, 16'h0001, 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b1);
        op16(16'h7FFF, 16'h8000, 1'b1);

        // Start request during RUN must be ignored
        wait_ready16();
        el = explat(64'd4, 16);
        pulse = (el - 1 >= 5) ? 5 : 1;
        a16 = 16'h0003; b16 = 16'h0004; sm16 = 1'b0; start16 = 1'b1;
        q16.push_back(32'h0000000C);
        @(negedge clk);
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 100) begin
            if (lat == pulse) begin
                a16 = 16'h0007; b16 = 16'h0007; start16 = 1'b1;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start16 = 1'b0;
        chk("lat_ignore", lat, el);
        last16 = 32'h0000000C;
        repeat (20) @(negedge clk);
        chk("prod_hold", product16, 32'h0000000C);
        chk("idle_ready", ready16, 1);

        // Reset mid-operation aborts and clears
        a16 = 16'h00FF; b16 = 16'h00FF; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_prod", product16, 0);
        chk("abort_ready", ready16, 1);
        chk("abort_busy", busy16, 0);
        chk("abort_done", done16, 0);
        @(negedge clk);
        rst = 1'b1;
        last16 = '0;
        op16(16'h0002, 16'h0003, 1'b0);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                op4(4'(i >> 4), 4'(i), 1'(s));

        repeat (10) @(negedge clk);
        chk("q16_empty", q16.size(), 0);
        chk("q4_empty", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Parametrised sequential shift-and-add multiplier and the successor to the fixed-width multiplier shift register. It adds a control FSM, a start/busy/done handshake, an internal accumulator and signed/unsigned operation. It sits between the operand-load logic and the result consumer in the arithmetic datapath. One partial product is processed per clock.

Parameters:
DATA_W, 16, operand width in bits; legal range 2..64; product is 2*DATA_W bits.
CNT_W, $clog2(DATA_W)+1, width of the iteration counter; derived, not overridden.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
signed_mode  input  1  1 = operands and product are two's complement, 0 = unsigned; sampled with start
op_a  input  DATA_W  multiplicand; shifted left inside the block
op_b  input  DATA_W  multiplier; shifted right, LSB selects the add
product  output  2*DATA_W  result register; holds last result until the next DONE
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; product is valid in that cycle
ready  output  1  high in IDLE only

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, product=0, accumulator=0, shift registers=0, counter=0, busy=0, done=0, ready=1. Reset asserted mid-operation aborts immediately and discards the partial result.
- States:
  - IDLE: ready=1. start=1 loads the operand registers, clears the accumulator and counter, and moves to RUN. start=0 stays in IDLE.
  - RUN: one iteration per cycle:
    - if b_reg[0], acc <= acc + a_reg (2*DATA_W-bit add, no overflow possible);
    - a_reg <= a_reg<<1 (2*DATA_W wide, zero fill);
    - b_reg <= b_reg>>1 (zero fill);
    - cnt++.
    - Moves to DONE after the iteration with cnt==DATA_W-1, so RUN lasts exactly DATA_W cycles (see Optional Feature).
  - DONE: for exactly one cycle, done=1 and product shows the final value. Next state is IDLE unconditionally.
- Product update: the product register is written when the FSM leaves RUN and holds at all other times. It keeps the previous result during RUN.
- Operand load, signed_mode=1:
  - a_reg gets |op_a| and b_reg gets |op_b|, computed as DATA_W-bit unsigned magnitudes.
  - neg_flag = op_a[MSB] ^ op_b[MSB].
  - Most-negative input (-2^(DATA_W-1)) maps to magnitude 2^(DATA_W-1), which is representable.
- Operand load, signed_mode=0: raw operands are loaded and neg_flag=0.
- Final value: product <= neg_flag ? -acc : acc (2*DATA_W two's complement). If the magnitude product is 0, the result is 0 regardless of neg_flag.
- Latency: start sampled at edge E0; done high in the cycle following edge E_DATA_W+1, i.e. DATA_W+1 cycles after the start cycle. Back-to-back throughput is one result per DATA_W+2 cycles.
- start while busy (RUN or DONE) is ignored with no side effects. Operand and signed_mode changes after the start cycle have no effect.
- start held high continuously: a new operation is accepted on each return to IDLE.
- busy and done are registered outputs, glitch-free.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined: RUN also exits to DONE when the post-shift b_reg value is zero, so remaining all-zero multiplier bits are skipped. Latency becomes (index of the highest set bit of |op_b|)+1 RUN cycles, minimum 1 RUN cycle when |op_b|=0. The product value is identical to the non-early case.
- Not defined: RUN always lasts exactly DATA_W cycles, giving fixed latency.

Test Plan:
1. DATA_W=16, unsigned, op_a=0xFFFF, op_b=0xFFFF, start 1 cycle -> product=0xFFFE0001; done pulse exactly 17 cycles after the start cycle; busy high 17 cycles; ready low throughout.
2. Signed: op_a=0xFFFD (-3), op_b=0x0005 -> product=0xFFFFFFF1 (-15). Signed: op_a=0x8000, op_b=0x8000 -> product=0x40000000. Signed: op_a=0x8000, op_b=0x0001 -> product=0xFFFF8000.
3. Unsigned op_a=0x1234, op_b=0x0000 -> product=0. With EARLY_TERM_EN, op_b=0x0001 -> done 2 cycles after start and product=0x00001234; without the macro, done at 17 cycles.
4. Start 0x0003*0x0004 (product 12), then pulse start with 0x0007*0x0007 during RUN cycle 5 -> second request ignored; product=0x0000000C at done; product holds 0x0000000C until the next accepted start completes.
5. Start 0x00FF*0x00FF, drop rst at RUN cycle 8 for 1 cycle -> all outputs return to reset values immediately (product=0, ready=1); a fresh 0x0002*0x0003 afterwards -> 0x00000006 with normal latency.
6. DATA_W=4 instance, random exhaustive sweep of both modes (256 pairs each) -> every product matches the reference model; done never asserted outside DONE.
